// File: rtl/pkt_wr_arbiter.sv
// Packet write-path arbiter: 16 ingress ports, strict priority with per-level round-robin, grant held per packet.
// Optional starvation relief via per-port age counters when ARB_AGING_EN is defined.
module pkt_wr_arbiter #(
    parameter int N_PORT = 16,
    parameter int LEN_W  = 9,
    parameter int PRIO_W = 3
`ifdef ARB_AGING_EN
    , parameter int AGE_LIMIT = 15
`endif
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_PORT-1:0]                         req,
    input  logic [N_PORT-1:0][LEN_W+PRIO_W+4-1:0]     req_ctrl,
    input  logic                                      beat_vld,
    output logic [N_PORT-1:0]                         grant,
    output logic                                      grant_vld,
    output logic [LEN_W+PRIO_W+4-1:0]                 grant_ctrl,
    output logic [LEN_W-1:0]                          wr_cnt,
    output logic                                      pkt_done,
    output logic                                      err_len
);

    localparam int DEST_W = 4;
    localparam int CTRL_W = LEN_W + PRIO_W + DEST_W;
    localparam int PTR_W  = $clog2(N_PORT);
    localparam int N_LVL  = 1 << PRIO_W;

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t                  state_reg, state_next;
    logic [N_PORT-1:0]       grant_reg, grant_next;
    logic                    grant_vld_reg, grant_vld_next;
    logic [CTRL_W-1:0]       grant_ctrl_reg, grant_ctrl_next;
    logic [LEN_W-1:0]        wr_cnt_reg, wr_cnt_next;
    logic                    pkt_done_reg, pkt_done_next;
    logic [PTR_W-1:0]        win_idx_reg, win_idx_next;
    logic [PRIO_W-1:0]       win_lvl_reg, win_lvl_next;
    logic [PTR_W-1:0]        ptr_reg [N_LVL];
    logic                    ptr_adv;

    logic [LEN_W-1:0]        port_len  [N_PORT];
    logic [PRIO_W-1:0]       port_prio [N_PORT];
    logic [N_PORT-1:0]       len_zero;
    logic [N_PORT-1:0]       eligible;
    logic [N_LVL-1:0][N_PORT-1:0] lvl_mask;
    logic [N_PORT-1:0]       sel_mask;
    logic [PRIO_W-1:0]       sel_lvl;
    logic [PTR_W-1:0]        sel_ptr;
    logic [PTR_W-1:0]        win_idx;
    logic [N_PORT-1:0]       win_onehot;
    logic [LEN_W-1:0]        grant_len;

    genvar gi, gl;

    generate
        for (gi = 0; gi < N_PORT; gi++) begin : g_field
            assign port_len[gi]  = req_ctrl[gi][CTRL_W-1 -: LEN_W];
            assign port_prio[gi] = req_ctrl[gi][DEST_W +: PRIO_W];
            assign len_zero[gi]  = (port_len[gi] == '0);
        end
        for (gl = 0; gl < N_LVL; gl++) begin : g_lvl
            for (gi = 0; gi < N_PORT; gi++) begin : g_port
                assign lvl_mask[gl][gi] = eligible[gi] && (port_prio[gi] == PRIO_W'(gl));
            end
        end
    endgenerate

    assign eligible = req & ~len_zero;
    assign err_len  = |(req & len_zero);

`ifdef ARB_AGING_EN
    logic [N_PORT-1:0] aged_mask;

    generate
        for (gi = 0; gi < N_PORT; gi++) begin : g_age
            logic [3:0] age_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    age_reg <= '0;
                end else if (!req[gi]) begin
                    age_reg <= '0;
                end else if (state_reg == IDLE && |eligible) begin
                    if (win_idx == PTR_W'(gi))
                        age_reg <= '0;
                    else if (eligible[gi] && age_reg != 4'hF)
                        age_reg <= age_reg + 4'd1;
                end
            end

            assign aged_mask[gi] = eligible[gi] && (int'(age_reg) >= AGE_LIMIT);
        end
    endgenerate
`endif

    // Highest populated level wins; aged ports (if enabled) outrank every level and share level-7's pointer.
    always_comb begin
        logic found;
        found    = 1'b0;
        sel_lvl  = '0;
        sel_mask = '0;
        for (int l = N_LVL - 1; l >= 0; l--) begin
            if (!found && |lvl_mask[l]) begin
                found    = 1'b1;
                sel_lvl  = PRIO_W'(l);
                sel_mask = lvl_mask[l];
            end
        end
`ifdef ARB_AGING_EN
        if (|aged_mask) begin
            sel_lvl  = PRIO_W'(N_LVL - 1);
            sel_mask = aged_mask;
        end
`endif
    end

    assign sel_ptr = ptr_reg[sel_lvl];

    always_comb begin
        logic hit;
        int   cand;
        hit     = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N_PORT; k++) begin
            cand = (int'(sel_ptr) + k) % N_PORT;
            if (!hit && sel_mask[cand]) begin
                hit     = 1'b1;
                win_idx = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    assign grant_len = grant_ctrl_reg[CTRL_W-1 -: LEN_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            grant_vld_reg  <= 1'b0;
            grant_ctrl_reg <= '0;
            wr_cnt_reg     <= '0;
            pkt_done_reg   <= 1'b0;
            win_idx_reg    <= '0;
            win_lvl_reg    <= '0;
            for (int l = 0; l < N_LVL; l++)
                ptr_reg[l] <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            grant_vld_reg  <= grant_vld_next;
            grant_ctrl_reg <= grant_ctrl_next;
            wr_cnt_reg     <= wr_cnt_next;
            pkt_done_reg   <= pkt_done_next;
            win_idx_reg    <= win_idx_next;
            win_lvl_reg    <= win_lvl_next;
            if (ptr_adv)
                ptr_reg[win_lvl_reg] <= (win_idx_reg == PTR_W'(N_PORT - 1)) ? '0 : win_idx_reg + PTR_W'(1);
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        grant_vld_next  = grant_vld_reg;
        grant_ctrl_next = grant_ctrl_reg;
        wr_cnt_next     = wr_cnt_reg;
        pkt_done_next   = 1'b0;
        win_idx_next    = win_idx_reg;
        win_lvl_next    = win_lvl_reg;
        ptr_adv         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|eligible) begin
                    state_next      = XFER;
                    grant_next      = win_onehot;
                    grant_vld_next  = 1'b1;
                    grant_ctrl_next = req_ctrl[win_idx];
                    wr_cnt_next     = '0;
                    win_idx_next    = win_idx;
                    win_lvl_next    = sel_lvl;
                end
            end
            XFER: begin
                if (beat_vld) begin
                    if (wr_cnt_reg == grant_len - LEN_W'(1)) begin
                        state_next     = GAP;
                        wr_cnt_next    = '0;
                        grant_next     = '0;
                        grant_vld_next = 1'b0;
                        pkt_done_next  = 1'b1;
                    end else begin
                        wr_cnt_next = wr_cnt_reg + LEN_W'(1);
                    end
                end
            end
            GAP: begin
                state_next = IDLE;
                ptr_adv    = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant      = grant_reg;
    assign grant_vld  = grant_vld_reg;
    assign grant_ctrl = grant_ctrl_reg;
    assign wr_cnt     = wr_cnt_reg;
    assign pkt_done   = pkt_done_reg;

endmodule

// File: tb/tb_pkt_wr_arbiter.sv
// Directed bench for pkt_wr_arbiter: expected winners are queued at stimulus time and checked at each grant.
module tb_pkt_wr_arbiter;

    logic               clk = 1'b0;
    logic               rst;
    logic [15:0]        req;
    logic [15:0][15:0]  req_ctrl;
    logic               beat_vld;
    logic [15:0]        grant;
    logic               grant_vld;
    logic [15:0]        grant_ctrl;
    logic [8:0]         wr_cnt;
    logic               pkt_done;
    logic               err_len;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

`ifdef ARB_AGING_EN
    pkt_wr_arbiter #(.AGE_LIMIT(3)) dut (
`else
    pkt_wr_arbiter dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_ctrl   (req_ctrl),
        .beat_vld   (beat_vld),
        .grant      (grant),
        .grant_vld  (grant_vld),
        .grant_ctrl (grant_ctrl),
        .wr_cnt     (wr_cnt),
        .pkt_done   (pkt_done),
        .err_len    (err_len)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int p, input int len, input int prio);
        req_ctrl[p] = {9'(len), 3'(prio), 4'(p)};
        req[p]      = 1'b1;
    endtask

    // mode 0: keep requests, 1: drop winner (and scramble its ctrl), 2: drop all requests
    task automatic serve(input int mode, output int waited);
        int          exp_port;
        int          len;
        logic [15:0] exp_ctrl;
        logic [15:0] exp_oh;
        waited = 0;
        while (grant_vld !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        check("grant_vld_timeout", grant_vld, 1);
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed grant 0x%0h expected no grant", grant);
        end
        exp_port = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
        exp_oh           = '0;
        exp_oh[exp_port] = 1'b1;
        exp_ctrl         = req_ctrl[exp_port];
        check("grant", grant, exp_oh);
        check("grant_ctrl", grant_ctrl, exp_ctrl);
        $display("grant: port %0d len %0d prio %0d observed grant 0x%04h", exp_port,
                 int'(exp_ctrl[15:7]), int'(exp_ctrl[6:4]), grant);
        if (mode == 1) begin
            req[exp_port]      = 1'b0;
            req_ctrl[exp_port] = 16'hFFFF;
        end else if (mode == 2) begin
            req = '0;
        end
        len = int'(exp_ctrl[15:7]);
        for (int b = 0; b < len; b++) begin
            check("wr_cnt", wr_cnt, b);
            check("grant_ctrl_frozen", grant_ctrl, exp_ctrl);
            beat_vld = 1'b1;
            step();
        end
        beat_vld = 1'b0;
        check("pkt_done", pkt_done, 1);
        check("gap_grant", grant, 0);
        check("gap_grant_vld", grant_vld, 0);
        check("gap_wr_cnt", wr_cnt, 0);
        step();
        check("pkt_done_pulse", pkt_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst      = 1'b1;
        req      = '0;
        req_ctrl = '0;
        beat_vld = 1'b0;
        step();
        step();
        check("rst_grant", grant, 0);
        check("rst_grant_vld", grant_vld, 0);
        check("rst_grant_ctrl", grant_ctrl, 0);
        check("rst_wr_cnt", wr_cnt, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_err_len", err_len, 0);
        rst = 1'b0;
        step();

        // 1: stray beat in IDLE ignored, then single port, len 4
        beat_vld = 1'b1;
        step();
        beat_vld = 1'b0;
        check("idle_beat_wr_cnt", wr_cnt, 0);
        check("idle_beat_grant_vld", grant_vld, 0);
        post(3, 4, 2);
        exp_q.push_back(3);
        serve(1, w);
        check("t1_latency", w, 1);

        // 2: strict priority then RR inside level 5
        post(1, 1, 5);
        post(9, 1, 5);
        post(4, 1, 7);
        exp_q.push_back(4);
        exp_q.push_back(1);
        exp_q.push_back(9);
        for (int i = 0; i < 3; i++) begin
            serve(1, w);
            check("t2_latency", w, 1);
        end

        // 3: RR wrap with continuous requests
        post(0, 1, 3);
        post(5, 1, 3);
        post(10, 1, 3);
        exp_q.push_back(0);
        exp_q.push_back(5);
        exp_q.push_back(10);
        exp_q.push_back(0);
        exp_q.push_back(5);
        for (int i = 0; i < 5; i++) begin
            serve((i == 4) ? 2 : 0, w);
            check("t3_latency", w, 1);
        end

        // 4: len==0 port excluded and flagged
        post(2, 0, 6);
        #1;
        check("t4_err_len", err_len, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_no_grant", grant, 0);
            check("t4_no_grant_vld", grant_vld, 0);
        end
        post(7, 2, 1);
        exp_q.push_back(7);
        serve(1, w);
        check("t4_err_len_held", err_len, 1);
        req[2] = 1'b0;
        #1;
        check("t4_err_len_clear", err_len, 0);
        step();

        // 5: reset mid-packet
        post(8, 8, 4);
        step();
        check("t5_grant", grant, 16'h0100);
        beat_vld = 1'b1;
        step();
        step();
        beat_vld = 1'b0;
        check("t5_wr_cnt_mid", wr_cnt, 2);
        rst = 1'b1;
        #1;
        check("t5_rst_grant", grant, 0);
        check("t5_rst_grant_vld", grant_vld, 0);
        check("t5_rst_wr_cnt", wr_cnt, 0);
        check("t5_rst_pkt_done", pkt_done, 0);
        step();
        check("t5_rst_pkt_done2", pkt_done, 0);
        step();
        rst = 1'b0;
        exp_q.push_back(8);
        serve(1, w);
        check("t5_regrant_latency", w, 1);

        // 6: low-priority starvation, relieved only by aging
        post(6, 1, 0);
        post(7, 1, 7);
`ifdef ARB_AGING_EN
        exp_q.push_back(7);
        exp_q.push_back(7);
        exp_q.push_back(7);
        exp_q.push_back(6);
        for (int i = 0; i < 4; i++)
            serve((i == 3) ? 2 : 0, w);
`else
        for (int i = 0; i < 20; i++)
            exp_q.push_back(7);
        for (int i = 0; i < 20; i++)
            serve((i == 19) ? 2 : 0, w);
`endif
        check("scoreboard_drained", exp_q.size(), 0);
        step();
        check("final_idle", grant_vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
